// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the two-client AXI4-Lite master arbiter.
package axi4lite_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_ADDR_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester always wins, on a tie the
// client that was not granted last time wins. The history bit lives in the top.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant, or zero when disabled or nobody is asking
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || last_grant)) begin
        grant[0] = 1'b1;
      end else if (req[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_4lite_master_arbiter.sv
// Shares one AXI4-Lite master port between two request/done clients, running
// a single transaction at a time and handing results back to the winner.
module axi_4lite_master_arbiter
  import axi4lite_pkg::*;
#(
  parameter int AXI_Dwidth    = AXI_DATA_W,
  parameter int AXI_Addrwidth = AXI_ADDR_W
) (
  input  logic                      AXI_aclk,
  input  logic                      AXI_aresetn,

  input  logic                      C0_req,
  input  logic                      C0_we,
  input  logic [AXI_Addrwidth-1:0]  C0_addr,
  input  logic [AXI_Dwidth-1:0]     C0_wdata,
  input  logic [AXI_Dwidth/8-1:0]   C0_wstrb,
  output logic                      C0_done,
  output logic [AXI_Dwidth-1:0]     C0_rdata,
  output logic [1:0]                C0_resp,

  input  logic                      C1_req,
  input  logic                      C1_we,
  input  logic [AXI_Addrwidth-1:0]  C1_addr,
  input  logic [AXI_Dwidth-1:0]     C1_wdata,
  input  logic [AXI_Dwidth/8-1:0]   C1_wstrb,
  output logic                      C1_done,
  output logic [AXI_Dwidth-1:0]     C1_rdata,
  output logic [1:0]                C1_resp,

  output logic                      busy,

  output logic [AXI_Addrwidth-1:0]  M_AXI_awaddr,
  output logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  output logic [AXI_Dwidth-1:0]     M_AXI_wdata,
  output logic [AXI_Dwidth/8-1:0]   M_AXI_wstrb,
  output logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  input  logic [1:0]                M_AXI_bresp,
  input  logic                      M_AXI_bvalid,
  output logic                      M_AXI_bready,
  output logic [AXI_Addrwidth-1:0]  M_AXI_areadaddr,
  output logic [2:0]                M_AXI_arprotect,
  output logic                      M_AXI_arvalid,
  input  logic                      M_AXI_arready,
  input  logic [AXI_Dwidth-1:0]     M_AXI_rdata,
  input  logic [1:0]                M_AXI_rresp,
  input  logic                      M_AXI_rvalid,
  output logic                      M_AXI_rready
);

  state_e                    state_q;
  logic                      lastGrant_q;
  logic                      owner_q;
  logic [AXI_Addrwidth-1:0]  addr_q;
  logic [AXI_Dwidth-1:0]     wdata_q;
  logic [AXI_Dwidth/8-1:0]   wstrb_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic [1:0]                done_q;
  logic [AXI_Dwidth-1:0]     c0Rdata_q;
  logic [AXI_Dwidth-1:0]     c1Rdata_q;
  logic [1:0]                c0Resp_q;
  logic [1:0]                c1Resp_q;

  logic [1:0]                grant;
  logic                      selWe;
  logic [AXI_Addrwidth-1:0]  selAddr;
  logic [AXI_Dwidth-1:0]     selWdata;
  logic [AXI_Dwidth/8-1:0]   selWstrb;
  logic                      awDone;
  logic                      wDone;

  rr_arbiter_2 u_arb (
    .req        ({C1_req, C0_req}),
    .enable     (state_q == ST_IDLE),
    .last_grant (lastGrant_q),
    .grant      (grant)
  );

  assign selWe    = grant[1] ? C1_we    : C0_we;
  assign selAddr  = grant[1] ? C1_addr  : C0_addr;
  assign selWdata = grant[1] ? C1_wdata : C0_wdata;
  assign selWstrb = grant[1] ? C1_wstrb : C0_wstrb;

  // A write channel counts as finished once its valid is already down or is being accepted now
  assign awDone = !awvalid_q || M_AXI_awready;
  assign wDone  = !wvalid_q  || M_AXI_wready;

  // Transaction sequencer: grant, AXI handshakes, result capture and done pulse
  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      done_q      <= 2'b00;
      c0Rdata_q   <= '0;
      c1Rdata_q   <= '0;
      c0Resp_q    <= RESP_OKAY;
      c1Resp_q    <= RESP_OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            owner_q     <= grant[1];
            lastGrant_q <= grant[1];
            addr_q      <= selAddr;
            wdata_q     <= selWdata;
            wstrb_q     <= selWstrb;
            if (selWe) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (M_AXI_awready) awvalid_q <= 1'b0;
          if (M_AXI_wready)  wvalid_q  <= 1'b0;
          if (awDone && wDone) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_bvalid) begin
            bready_q        <= 1'b0;
            done_q[owner_q] <= 1'b1;
            if (owner_q) c1Resp_q <= M_AXI_bresp;
            else         c0Resp_q <= M_AXI_bresp;
            state_q         <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (M_AXI_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (M_AXI_rvalid) begin
            rready_q        <= 1'b0;
            done_q[owner_q] <= 1'b1;
            if (owner_q) begin
              c1Rdata_q <= M_AXI_rdata;
              c1Resp_q  <= M_AXI_rresp;
            end else begin
              c0Rdata_q <= M_AXI_rdata;
              c0Resp_q  <= M_AXI_rresp;
            end
            state_q         <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 2'b00;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign C0_done         = done_q[0];
  assign C1_done         = done_q[1];
  assign C0_rdata        = c0Rdata_q;
  assign C1_rdata        = c1Rdata_q;
  assign C0_resp         = c0Resp_q;
  assign C1_resp         = c1Resp_q;
  assign M_AXI_awaddr    = addr_q;
  assign M_AXI_areadaddr = addr_q;
  assign M_AXI_wdata     = wdata_q;
  assign M_AXI_wstrb     = wstrb_q;
  assign M_AXI_awvalid   = awvalid_q;
  assign M_AXI_wvalid    = wvalid_q;
  assign M_AXI_bready    = bready_q;
  assign M_AXI_arvalid   = arvalid_q;
  assign M_AXI_rready    = rready_q;
  assign M_AXI_arprotect = 3'b000;

endmodule

// File: doc/axi_4lite_master_arbiter.md
# axi_4lite_master_arbiter

Two-requester AXI4-Lite master that shares one AXI4-Lite slave port between two internal clients, for example a processor-side bridge and a local sequencer.
- Each client issues single-beat read or write requests over a simple request/done interface.
- The block arbitrates round-robin, runs exactly one AXI4-Lite transaction at a time, and returns read data and response to the granted client.
- It sits directly in front of the 4-register AXI4-Lite slave (LED control register at offset 0x0).

## Interface
Parameters:
- AXI_Dwidth, 32, data width; must be 32.
- AXI_Addrwidth, 4, byte address width.

Ports:
- AXI_aclk  in  1  single clock for the whole block.
- AXI_aresetn  in  1  reset; asynchronous, active-low.
- Cn_req  in  1  (n = 0,1) request; hold high with fields stable until Cn_done.
- Cn_we  in  1  1 = write, 0 = read.
- Cn_addr  in  AXI_Addrwidth  byte address.
- Cn_wdata  in  AXI_Dwidth  write data.
- Cn_wstrb  in  AXI_Dwidth/8  write byte strobes.
- Cn_done  out  1  one-cycle completion pulse.
- Cn_rdata  out  AXI_Dwidth  read data; valid with Cn_done on reads, holds until the next completion for that client.
- Cn_resp  out  2  AXI response; valid with Cn_done.
- busy  out  1  high whenever the FSM is not IDLE.
- M_AXI_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, areadaddr/arprotect/arvalid/arready, rdata/rresp/rvalid/rready:
  - Standard AXI4-Lite master side; widths match the slave port of the same name.
  - M_AXI_arprotect is tied to 3'b000.

## Operation
- Reset values:
  - All Cn_done, busy, M_AXI_*valid and M_AXI_*ready outputs = 0.
  - Address, data and strobe outputs = 0; Cn_rdata and Cn_resp = 0.
  - last_grant = 1, so client 0 wins the first tie.
- Arbitration happens only in IDLE:
  - One requester high: grant it.
  - Both high: grant the client that is not last_grant.
  - On grant, latch we/addr/wdata/wstrb into internal registers and update last_grant.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
  - IDLE -> WR_REQ or RD_REQ on grant.
  - WR_REQ: drive awvalid and wvalid together with the latched fields.
    - Drop awvalid on the edge where awready is sampled high; drop wvalid independently on wready.
    - Go to WR_RESP once both handshakes have completed, in either order or the same cycle.
  - WR_RESP: bready = 1. On bvalid, capture bresp, then go to DONE.
  - RD_REQ: drive arvalid with areadaddr until arready is sampled high, then go to RD_RESP.
  - RD_RESP: rready = 1. On rvalid, capture rdata and rresp, then go to DONE.
  - DONE: pulse Cn_done for the granted client only, then go to IDLE.
- Valid signals never drop before their handshake completes.
- Address and data outputs are stable while the corresponding valid is high.
- Cn_req falling mid-transaction is ignored: the transaction completes and Cn_done still pulses.
- Cn_req high in the cycle after Cn_done is treated as a new request.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately (asynchronous) and the FSM returns to IDLE.
  - No done pulse is issued; the interrupted transaction is lost.
- No timeout: a slave that never responds stalls the block, and busy stays high.

## Timing
- Grant is registered: AXI valid rises 1 cycle after req is sampled in IDLE.
- Zero-wait slave (ready asserted the cycle after valid, response the cycle after the handshake):
  - Write: Cn_done 4 cycles after req sampled.
  - Read: Cn_done 4 cycles after req sampled.
- Minimum spacing between two completions is 1 IDLE cycle, so back-to-back grants are 5 cycles apart.
- Write and read responses are never outstanding simultaneously.

## Structure
- Shared package axi4lite_pkg holds:
  - FSM state enum.
  - Response constants: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Default widths: data 32, address 4.
- Sub-module rr_arbiter_2:
  - Inputs: req[1:0], enable, last_grant.
  - Output: grant[1:0], one-hot or zero.
  - Purely combinational; the last_grant register stays in the top level.

## Test plan
- C0 write 0x0000000F to addr 0x0 with wstrb 4'hF:
  - C0_done pulses once, C0_resp = 00.
  - A follow-up C0 read of 0x0 returns 0x0000000F, and slave LED = 4'hF.
- C0 and C1 raise req in the same cycle, C0 writing 0xA5 to 0x4 and C1 reading 0x4:
  - C0 is granted first and completes first.
  - C1 then returns rdata 0x000000A5.
- Both clients hold req continuously for 6 transactions: grants alternate 0,1,0,1,0,1.
- Slave model delays awready 3 cycles after wready and holds bvalid 2 cycles against a stalled bready:
  - awvalid stays high until its handshake completes.
  - Exactly one C0_done is issued.
- Assert reset during RD_RESP:
  - arvalid, rready and busy drop asynchronously; no Cn_done is issued.
  - After release, a C1 write completes with resp 00.
